// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with a busy scoreboard and a sequential post-reset clear.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle write data (and mask busy) on reads.
module regfile_mp #(
    parameter int REG_NUM = 32,
    parameter int XLEN    = 32,
    parameter int IDX_W   = 5,
    parameter int NUM_RD  = 2,
    parameter int NUM_WR  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_WR-1:0]       wr_en_i,
    input  logic [NUM_WR*IDX_W-1:0] wr_idx_i,
    input  logic [NUM_WR*XLEN-1:0]  wr_data_i,
    input  logic [NUM_RD-1:0]       rd_en_i,
    input  logic [NUM_RD*IDX_W-1:0] rd_idx_i,
    output logic [NUM_RD*XLEN-1:0]  rd_data_o,
    output logic [NUM_RD-1:0]       rd_busy_o,
    input  logic                    iss_en_i,
    input  logic [IDX_W-1:0]        iss_idx_i,
    input  logic                    flush_i,
    output logic                    rf_ready_o,
    output logic [XLEN-1:0]         rf_x1_rdata_o
);
    localparam logic [IDX_W:0]   REG_LIM  = (IDX_W+1)'(REG_NUM);
    localparam logic [IDX_W-1:0] CLR_LAST = IDX_W'(REG_NUM-1);

    typedef enum logic {INIT, RUN} state_t;

    state_t                              state_q, state_d;
    logic [IDX_W-1:0]                    clr_cnt, clr_d;
    logic                                ready_d;
    logic [REG_NUM-1:0]                  busy_q, busy_d;
    logic [XLEN-1:0]                     regs [REG_NUM];
    logic                                run;

    logic [NUM_WR-1:0][IDX_W-1:0]        w_idx;
    logic [NUM_WR-1:0][XLEN-1:0]         w_data;
    logic [NUM_RD-1:0][IDX_W-1:0]        r_idx;
    logic [NUM_RD-1:0][XLEN-1:0]         r_data;
    logic [NUM_WR-1:0]                   wr_ok;
    logic                                iss_ok;

    assign w_idx     = wr_idx_i;
    assign w_data    = wr_data_i;
    assign r_idx     = rd_idx_i;
    assign rd_data_o = r_data;
    assign run       = (state_q == RUN);

    for (genvar p = 0; p < NUM_WR; p++) begin : g_wr
        assign wr_ok[p] = run && wr_en_i[p] && (w_idx[p] != '0) && ({1'b0, w_idx[p]} < REG_LIM);
    end

    assign iss_ok = run && iss_en_i && (iss_idx_i != '0) && ({1'b0, iss_idx_i} < REG_LIM);

    // Clear sequencer
    always_comb begin
        state_d = state_q;
        clr_d   = clr_cnt;
        ready_d = rf_ready_o;
        if (state_q == INIT) begin
            clr_d = clr_cnt + 1'b1;
            if (clr_cnt == CLR_LAST) begin
                state_d = RUN;
                ready_d = 1'b1;
            end
        end
    end

    // Writebacks clear first so a same-cycle issue (new producer) keeps the bit set
    always_comb begin
        busy_d = busy_q;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_ok[p]) busy_d[w_idx[p]] = 1'b0;
        end
        if (iss_ok) busy_d[iss_idx_i] = 1'b1;
        if (flush_i) busy_d = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            clr_cnt    <= IDX_W'(1);
            busy_q     <= '0;
            rf_ready_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt    <= clr_d;
            busy_q     <= busy_d;
            rf_ready_o <= ready_d;
        end
    end

    // Array has no reset; INIT zeroes one entry per cycle. Ascending loop lets the higher port win.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == INIT) begin
                regs[clr_cnt] <= '0;
            end else begin
                for (int p = 0; p < NUM_WR; p++) begin
                    if (wr_ok[p]) regs[w_idx[p]] <= w_data[p];
                end
            end
        end
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        logic            rv;
        logic [XLEN-1:0] rdat;
        logic            rbsy;

        assign rv = run && rd_en_i[r] && (r_idx[r] != '0) && ({1'b0, r_idx[r]} < REG_LIM);

        always_comb begin
            rdat = '0;
            rbsy = 1'b0;
            if (rv) begin
                rdat = regs[r_idx[r]];
                rbsy = busy_q[r_idx[r]];
`ifdef REGFILE_MP_BYPASS_EN
                for (int p = 0; p < NUM_WR; p++) begin
                    if (wr_ok[p] && (w_idx[p] == r_idx[r])) begin
                        rdat = w_data[p];
                        rbsy = 1'b0;
                    end
                end
`endif
            end
        end

        assign r_data[r]    = rdat;
        assign rd_busy_o[r] = rbsy;
    end

    assign rf_x1_rdata_o = regs[1];

endmodule
